// File: rtl/dma_sequencer.sv
// -----------------------------------------------------------------------------
// dma_sequencer
//   Block-copy / fill engine behind the four DMA registers. It takes the shared
//   bus from the CPU and moves words from a source address to a destination
//   address. A copy costs two cycles per word (READ, WRITE). A fill costs one
//   cycle per word. Each transfer adds one GRANT cycle and one DONE cycle.
//
//   Optional build macro: DMA_BLANK_ONLY_EN
//     When defined, READ/WRITE steps advance only during blanking
//     (hbright=0 or vbright=0). During active video the engine parks in PAUSE
//     and releases the bus. It then resumes through GRANT with the saved
//     src/dst/cnt.
//
//   Ports
//     clk, rst           system clock, asynchronous active-low reset
//     reg_en/reg_mode    register window select / register index
//                        (0 SRC_L, 1 SRC_U control, 2 DST, 3 AMT)
//     reg_write/wdata    CPU write strobe and data
//     reg_rdata          combinational register readback
//     bus_addr/write/    DMA side of the shared bus; bus_rdata returns one
//     wdata/rdata        cycle after the address (synchronous memory)
//     bus_grant          DMA owns the bus
//     cpu_stall          freezes the CPU pipeline
//     hbright/vbright    active-video indicators (used only with the macro)
//     busy, done         transfer in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module dma_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_en,
   input  logic [1:0]        reg_mode,
   input  logic              reg_write,
   input  logic [DATA_W-1:0] reg_wdata,
   output logic [DATA_W-1:0] reg_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_grant,
   output logic              cpu_stall,
   input  logic              hbright,
   input  logic              vbright,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_READ, S_WRITE, S_DONE, S_PAUSE
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_ctrl;    // [0] FILL, [1] DST_HOLD
   logic              r_done;

   logic              w_wr;
   logic              w_fill;
   logic              w_hold;
   logic              w_blank;
   logic [DATA_W-1:0] w_ctrl_rd;

   assign w_wr   = reg_en & reg_write;
   assign w_fill = r_ctrl[0];
   assign w_hold = r_ctrl[1];

`ifdef DMA_BLANK_ONLY_EN
   assign w_blank = ~(hbright & vbright);
`else
   logic w_unused_blank;
   assign w_unused_blank = hbright ^ vbright;
   assign w_blank        = 1'b1;
`endif

   // Control FSM and the working address/count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_ctrl  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // The registers are writable only here. Writes arriving
               // mid-transfer (including AMT) fall through this case untouched.
               if (w_wr) begin
                  case (reg_mode)
                     2'd0: r_src  <= ADDR_W'(reg_wdata);
                     2'd1: r_ctrl <= reg_wdata[1:0];
                     2'd2: r_dst  <= ADDR_W'(reg_wdata);
                     2'd3: begin
                        r_cnt <= CNT_W'(reg_wdata);
                        if (CNT_W'(reg_wdata) == '0) r_done  <= 1'b1;
                        else                         r_state <= S_GRANT;
                     end
                     default: ;
                  endcase
               end
            end
            // Stall is already up here, so the CPU finishes its access
            // before the bus switches over.
            S_GRANT: r_state <= w_fill ? S_WRITE : S_READ;
            S_READ: begin
               r_state <= w_blank ? S_WRITE : S_PAUSE;
            end
            S_WRITE: begin
               if (!w_blank) begin
                  // The write is suppressed (bus_write gated). A copy re-reads
                  // the word after GRANT, so nothing is lost or repeated.
                  r_state <= S_PAUSE;
               end else begin
                  if (!w_fill) r_src <= r_src + ADDR_W'(1);
                  if (!w_hold) r_dst <= r_dst + ADDR_W'(1);
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (!w_fill) begin
                     r_state <= S_READ;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            S_PAUSE: if (w_blank) r_state <= S_GRANT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The bus controls decode straight from the state register, so reset
   // clears them immediately.
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign cpu_stall = (r_state == S_GRANT) | (r_state == S_READ) | (r_state == S_WRITE);
   assign bus_grant = (r_state == S_READ) | (r_state == S_WRITE);
   assign bus_write = (r_state == S_WRITE) & w_blank;

   always_comb begin
      bus_addr  = '0;
      bus_wdata = '0;
      if (r_state == S_READ) begin
         bus_addr = r_src;
      end else if (r_state == S_WRITE) begin
         bus_addr  = r_dst;
         // Fill data is the SRC_L value. A copy forwards the word fetched
         // in the preceding READ.
         bus_wdata = w_fill ? DATA_W'(r_src) : bus_rdata;
      end
   end

   always_comb begin
      w_ctrl_rd            = '0;
      w_ctrl_rd[DATA_W-1]  = busy;
      w_ctrl_rd[1:0]       = r_ctrl;
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_mode)
         2'd0: reg_rdata = DATA_W'(r_src);
         2'd1: reg_rdata = w_ctrl_rd;
         2'd2: reg_rdata = DATA_W'(r_dst);
         2'd3: reg_rdata = DATA_W'(r_cnt);
      endcase
   end

endmodule

// File: doc/dma_sequencer.md
Name: dma_sequencer

Overview:
Executes the block-copy and fill transfers programmed through the four memory-mapped DMA registers, base address 16'h4804, decoded by the memory controller as dma_en and dma_mode.
- Takes the shared data bus from the CPU, stalls the CPU, and copies words from program or VRAM space to any mapped destination, typically sprite, tile or palette RAM.
- Runs at two cycles per word, plus one arbitration cycle per transfer.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 16, bus data width
- CNT_W, 16, transfer count width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- reg_en  input  1  DMA register window selected (dma_en)
- reg_mode  input  2  register select: 0 SRC_L, 1 SRC_U (control), 2 DST, 3 AMT
- reg_write  input  1  CPU write strobe
- reg_wdata  input  DATA_W  CPU write data
- reg_rdata  output  DATA_W  register readback
- bus_addr  output  ADDR_W  DMA-driven address, valid while bus_grant=1
- bus_write  output  1  DMA write strobe
- bus_wdata  output  DATA_W  DMA write data
- bus_rdata  input  DATA_W  memory read data, one-cycle synchronous latency
- bus_grant  output  1  DMA owns the bus; top-level mux selects DMA over CPU
- cpu_stall  output  1  freezes CPU pipeline
- hbright  input  1  horizontal active video
- vbright  input  1  vertical active video
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when a transfer completes

Behaviour:
Reset (asynchronous, rst=0):
- All registers clear and state=IDLE.
- bus_grant, cpu_stall, bus_write, busy and done are 0; bus_addr and bus_wdata are 0.

Registers:
- SRC_L: source address.
- SRC_U control bits: [0] FILL (write the SRC_L value as data, with no reads); [1] DST_HOLD (destination does not increment); other bits read 0.
- Writes in IDLE update the register.
- Writes while busy are ignored, except that writing AMT while busy is also ignored and does not restart the transfer.

Start:
- An IDLE write to AMT loads cnt and moves to GRANT.
- AMT=0 produces no bus activity: done pulses the next cycle and the state stays IDLE.

States:
- IDLE: waits for a start.
- GRANT: asserts cpu_stall one cycle before bus_grant, so the CPU drains its current access; next state is READ, or WRITE if FILL=1.
- READ: drives bus_addr=src with bus_write=0; next state is WRITE.
- WRITE: drives bus_addr=dst, bus_wdata=bus_rdata (or SRC_L if FILL), bus_write=1.
  - src increments unless FILL; dst increments unless DST_HOLD; cnt decrements.
  - If cnt==1: next state is DONE. Otherwise next state is READ, or stays WRITE if FILL.
- DONE: drops bus_grant and cpu_stall, pulses done; next state is IDLE.

Signal timing:
- busy is high from GRANT through DONE inclusive.
- cpu_stall is high from GRANT through the final WRITE; bus_grant is high READ through WRITE.

Arithmetic:
- src and dst wrap modulo 2^ADDR_W (16'hFFFF+1 = 16'h0000); no other limit applies.

Readback:
- reg_rdata is combinational, for mode 0 through 3: live src; {busy,13'b0,ctrl[1:0]}; live dst; remaining cnt.

Optional Feature:
- Macro DMA_BLANK_ONLY_EN.
- Defined: READ and WRITE steps advance only when hbright=0 or vbright=0 (blanking). During active video the FSM holds in a PAUSE state with bus_grant=0 and cpu_stall=0, so the CPU runs. On return to blanking it re-enters GRANT and resumes at the saved src/dst/cnt; no word is lost or duplicated.
- Undefined: the blanking inputs are ignored and the transfer runs uninterrupted.

Test Plan:
- Copy: SRC_L=16'h0100, ctrl=0, DST=16'h2000, AMT=4 with memory 0x0100..0x0103 = A,B,C,D -> sprite 0x2000..0x2003 = A,B,C,D; busy high 10 cycles; done pulses once; cpu_stall covers every bus cycle.
- Fill with hold: SRC_L=16'h1234, ctrl=3, DST=16'h4400, AMT=3 -> three writes of 16'h1234 to 16'h4400 on consecutive cycles; no reads issued.
- Zero and ignore: AMT=0 -> done pulse, no bus_grant. During a 4-word copy, write AMT=9 and DST=0 -> ignored; exactly 4 words written.
- Wrap: DST=16'hFFFF, AMT=2 -> writes to 16'hFFFF then 16'h0000; final readback DST=16'h0001.
- Reset mid-transfer: drop rst during WRITE of word 2 -> outputs are 0 immediately (asynchronous); after release, state is IDLE and readback returns 0 for all registers.
- With DMA_BLANK_ONLY_EN: an 8-word copy where hbright=vbright=1 after word 3 for 20 cycles -> bus released, stall low, then words 4..8 are written once each to the correct destinations.
